// File: rtl/mcu_bus_pkg.sv
// rtl/mcu_bus_pkg.sv - shared IO register map, UART state type and baud helper
package mcu_bus_pkg;

    // Address bit that selects the IO page; firmware headers use the same value
    localparam int unsigned IO_BIT_DEFAULT = 22;

    // IO register word offsets within the page
    localparam logic [2:0] REG_LEDS        = 3'd0;
    localparam logic [2:0] REG_UART_DATA   = 3'd1;
    localparam logic [2:0] REG_UART_STATUS = 3'd2;
    localparam logic [2:0] REG_CYCLE       = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Clocks per UART bit, never below 2 so the baud counter always has a width
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        int unsigned cpb;
        cpb = clk_hz / baud;
        return (cpb < 2) ? 2 : cpb;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 LSB-first UART transmitter with registered line output
module uart_tx
    import mcu_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;

    assign tx   = tx_q;
    assign busy = busy_q;

    // Frame sequencer: each bit is held for exactly CLKS_PER_BIT cycles; starts are ignored unless idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q <= data;
                        baud_q  <= '0;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_q == LAST) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_q == LAST) begin
                        baud_q <= '0;
                        if (idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_q == LAST) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mcu_bus.sv
// rtl/mcu_bus.sv - MCU memory-port slave: BRAM, MMIO page and address decoder
module mcu_bus
    import mcu_bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned IO_BIT    = IO_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_rstrb,
    input  logic        mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int unsigned AW  = $clog2(MEM_WORDS);
    localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);

    logic [31:0]   ram_q [MEM_WORDS];
    logic [31:0]   rdata_q;
    logic [31:0]   rdata_d;
    logic [7:0]    leds_q;
    logic [31:0]   cycle_q;
    logic          sel_io;
    logic [AW-1:0] word_idx;
    logic [2:0]    reg_idx;
    logic          uart_start;
    logic          uart_busy;
    logic          unused_addr;

    // Upper address bits are don't-care, which is what makes the RAM alias
    assign unused_addr = ^mem_addr;

    assign sel_io     = mem_addr[IO_BIT];
    assign word_idx   = mem_addr[AW+1:2];
    assign reg_idx    = mem_addr[4:2];
    assign uart_start = mem_wstrb && sel_io && (reg_idx == REG_UART_DATA);

    assign mem_rdata = rdata_q;
    assign leds      = leds_q;

    // Read mux over pre-edge state, so a same-edge write never leaks into the read
    always_comb begin
        rdata_d = '0;
        if (!sel_io) begin
            rdata_d = ram_q[word_idx];
        end else begin
            case (reg_idx)
                REG_LEDS:        rdata_d = {24'b0, leds_q};
                REG_UART_STATUS: rdata_d = {31'b0, uart_busy};
                REG_CYCLE:       rdata_d = cycle_q;
                default:         rdata_d = '0;
            endcase
        end
    end

    // Read data is captured only on a read strobe and held otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (mem_rstrb) begin
            rdata_q <= rdata_d;
        end
    end

    // Full-word RAM store; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_wstrb && !sel_io) begin
            ram_q[word_idx] <= mem_wdata;
        end
    end

    // LED register takes the low byte of a store
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            leds_q <= '0;
        end else if (mem_wstrb && sel_io && (reg_idx == REG_LEDS)) begin
            leds_q <= mem_wdata[7:0];
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) u_uart_tx (
        .clk  (clk),
        .rstn (rstn),
        .start(uart_start),
        .data (mem_wdata[7:0]),
        .tx   (uart_tx),
        .busy (uart_busy)
    );

endmodule

// File: tb/tb_mcu_bus.sv
// tb/tb_mcu_bus.sv - randomized self-checking bench for mcu_bus against a frame-timing model
module tb_mcu_bus;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_rstrb = 1'b0;
    logic        mem_wstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic [7:0]  leds;
    logic        uart_tx;

    mcu_bus #(
        .MEM_WORDS(1024),
        .CLK_HZ   (1000),
        .BAUD     (250),
        .IO_BIT   (22)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rstrb(mem_rstrb),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .leds     (leds),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: sparse RAM, registers, and a frame described by its start edge
    logic [31:0] m_ram [int];
    logic [31:0] m_rdata = '0;
    bit          m_rdata_known = 1'b1;
    logic [7:0]  m_leds = '0;
    logic [31:0] m_cycle = '0;
    int          edge_no = 0;
    int          m_t0 = 0;
    logic [7:0]  m_byte = '0;
    bit          m_frame = 1'b0;
    bit          chk_en = 1'b0;

    function automatic bit m_busy_at(input int n);
        return m_frame && (n - m_t0 >= 0) && (n - m_t0 < FRAME);
    endfunction

    function automatic logic m_tx_at(input int n);
        int slot;
        if (!m_busy_at(n)) return 1'b1;
        slot = (n - m_t0) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rdata       = '0;
        m_rdata_known = 1'b1;
        m_leds        = '0;
        m_cycle       = '0;
        m_frame       = 1'b0;
    endtask

    // Apply one posedge worth of bus semantics using the inputs held across the edge
    task automatic model_edge();
        int          widx;
        logic [2:0]  ridx;
        bit          io;
        bit          pre_busy;
        edge_no++;
        widx     = int'(mem_addr[11:2]);
        ridx     = mem_addr[4:2];
        io       = mem_addr[22];
        pre_busy = m_busy_at(edge_no - 1);
        if (mem_rstrb) begin
            if (io) begin
                m_rdata_known = 1'b1;
                case (ridx)
                    3'd0:    m_rdata = {24'b0, m_leds};
                    3'd2:    m_rdata = {31'b0, pre_busy};
                    3'd3:    m_rdata = m_cycle;
                    default: m_rdata = '0;
                endcase
            end else if (m_ram.exists(widx)) begin
                m_rdata_known = 1'b1;
                m_rdata       = m_ram[widx];
            end else begin
                m_rdata_known = 1'b0;
            end
        end
        if (mem_wstrb) begin
            if (!io) m_ram[widx] = mem_wdata;
            else if (ridx == 3'd0) m_leds = mem_wdata[7:0];
            else if (ridx == 3'd1 && !pre_busy) begin
                m_frame = 1'b1;
                m_t0    = edge_no;
                m_byte  = mem_wdata[7:0];
            end
        end
        m_cycle = m_cycle + 32'd1;
    endtask

    // Compare all outputs against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en && rstn) begin
            if (m_rdata_known) check("rdata", mem_rdata, m_rdata);
            check("leds", {24'b0, leds}, {24'b0, m_leds});
            check("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx_at(edge_no)});
        end
    end

    // One bus cycle; entered and left just after a negedge
    task automatic step(input logic [31:0] a, input logic [31:0] d, input bit r, input bit w);
        mem_addr  = a;
        mem_wdata = d;
        mem_rstrb = r;
        mem_wstrb = w;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        mem_rstrb = 1'b0;
        mem_wstrb = 1'b0;
    endtask

    localparam logic [31:0] A_LEDS   = 32'h0040_0000;
    localparam logic [31:0] A_UDATA  = 32'h0040_0004;
    localparam logic [31:0] A_STATUS = 32'h0040_0008;
    localparam logic [31:0] A_CYCLE  = 32'h0040_000C;

    initial begin
        logic [9:0]  slots_55;
        logic [7:0]  got_byte;
        logic [31:0] c1;
        logic [31:0] a;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rdata", mem_rdata, 32'h0);
        check("reset leds", {24'b0, leds}, 32'h0);
        check("reset uart_tx", {31'b0, uart_tx}, 32'h1);
        rstn   = 1'b1;
        chk_en = 1'b1;

        // RAM write then read, rdata held across address changes without rstrb
        step(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step(32'h10, 32'h0, 1'b1, 1'b0);
        check("ram read", mem_rdata, 32'hDEAD_BEEF);
        step(32'h0, 32'h0, 1'b0, 1'b0);
        step(32'h0, 32'h0, 1'b0, 1'b0);
        check("ram hold", mem_rdata, 32'hDEAD_BEEF);

        // Aliasing above the index bits, and an unmapped IO slot
        step(32'h1010, 32'h1234, 1'b0, 1'b1);
        step(32'h10, 32'h0, 1'b1, 1'b0);
        check("ram alias", mem_rdata, 32'h0000_1234);
        step(32'h0040_0014, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(32'h0040_0014, 32'h0, 1'b1, 1'b0);
        check("io idx5", mem_rdata, 32'h0);

        // Same-edge read and write: old word returned
        step(32'h10, 32'hCAFE_F00D, 1'b1, 1'b1);
        check("ram rbw", mem_rdata, 32'h0000_1234);
        step(32'h10, 32'h0, 1'b1, 1'b0);
        check("ram after rbw", mem_rdata, 32'hCAFE_F00D);

        // LEDs
        step(A_LEDS, 32'hFFFF_FFA5, 1'b0, 1'b1);
        check("leds write", {24'b0, leds}, 32'hA5);
        step(A_LEDS, 32'h0, 1'b1, 1'b0);
        check("leds read", mem_rdata, 32'h0000_00A5);

        // Full 0x55 frame with a status read every cycle
        slots_55 = 10'b10_1010_1010;
        step(A_UDATA, 32'h55, 1'b0, 1'b1);
        check("frame k0", {31'b0, uart_tx}, 32'h0);
        for (int k = 1; k <= 41; k++) begin
            step(A_STATUS, 32'h0, 1'b1, 1'b0);
            if (k < FRAME) check($sformatf("frame k%0d", k), {31'b0, uart_tx}, {31'b0, slots_55[k/CPB]});
            else check($sformatf("idle k%0d", k), {31'b0, uart_tx}, 32'h1);
            if (k == 20) check("status mid", mem_rdata, 32'h1);
            if (k == 40) check("status at clear", mem_rdata, 32'h1);
            if (k == 41) check("status after", mem_rdata, 32'h0);
        end

        // Overrun: second write during the frame is dropped
        got_byte = '0;
        step(A_UDATA, 32'h41, 1'b0, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            if (k == 5) step(A_UDATA, 32'h42, 1'b0, 1'b1);
            else step(32'h0, 32'h0, 1'b0, 1'b0);
            if (k >= 6 && k <= 34 && (k % CPB) == 2) got_byte[k/CPB - 1] = uart_tx;
            if (k >= 40) check($sformatf("overrun idle k%0d", k), {31'b0, uart_tx}, 32'h1);
        end
        check("overrun byte", {24'b0, got_byte}, 32'h41);

        // Reset mid-frame: outputs return asynchronously
        step(A_UDATA, 32'h3C, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) step(32'h0, 32'h0, 1'b0, 1'b0);
        check("pre-reset tx", {31'b0, uart_tx}, 32'h0);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        check("async rdata", mem_rdata, 32'h0);
        check("async leds", {24'b0, leds}, 32'h0);
        check("async uart_tx", {31'b0, uart_tx}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 12; k++) step(32'h0, 32'h0, 1'b0, 1'b0);

        // Cycle counter: two reads 7 edges apart, then wrap
        step(A_CYCLE, 32'h0, 1'b1, 1'b0);
        c1 = mem_rdata;
        for (int k = 0; k < 6; k++) step(32'h0, 32'h0, 1'b0, 1'b0);
        step(A_CYCLE, 32'h0, 1'b1, 1'b0);
        check("cycle delta", mem_rdata - c1, 32'd7);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_q;
        m_cycle = 32'hFFFF_FFFF;
        step(A_CYCLE, 32'h0, 1'b1, 1'b0);
        check("cycle max", mem_rdata, 32'hFFFF_FFFF);
        step(A_CYCLE, 32'h0, 1'b1, 1'b0);
        check("cycle wrap", mem_rdata, 32'h0);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                a = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 7)) << 12);
            end else begin
                a = A_LEDS | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 24);
            end
            step(a, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
